// File: rtl/calc_sequencer.sv
// calc_sequencer: batch controller that adds the halves of each SRAM word and packs sum pairs into writes.
// Latency: 3 cycles per read word (READ/WAIT/ADD), 1 cycle per packed write, 1 DONE cycle.
// Backpressure: none; SRAM/adder/buffer are fixed-latency, and start_i is ignored while busy.
module calc_sequencer #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr,
  input  logic [ADDR_W-1:0]        read_end_addr,
  input  logic [ADDR_W-1:0]        write_start_addr,
  input  logic [ADDR_W-1:0]        write_end_addr,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] rd_data_i,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  input  logic [DATA_W-1:0]        sum_i,
  output logic                     buf_we_o,
  output logic                     buf_sel_o,
  input  logic [MEM_WORD_SIZE-1:0] buf_data_i,
  output logic                     wr_en_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [MEM_WORD_SIZE-1:0] wr_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_ADD   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Range lengths need two extra bits: a full 2^ADDR_W range doubled must not overflow.
  localparam int CW = ADDR_W + 2;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rptr;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W-1:0]   r_rd_end;
  logic                r_half;
  logic                r_rd_en;
  logic                r_buf_we;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;

  logic [CW-1:0]            w_nr;
  logic [CW-1:0]            w_nw;
  logic                     w_cfg_bad;
  logic                     w_last_rd;
  logic [MEM_WORD_SIZE-1:0] w_wr_data;

  // The adder result goes straight into the result buffer; the sequencer only
  // steers the capture strobe, so the sum port is carried for the top's wiring.
  logic w_unused_sum;
  assign w_unused_sum = ^sum_i;

  // Configuration check on the live inputs in the start cycle: both ranges must be
  // non-empty and the write range must hold at least ceil(NR/2) packed words.
  assign w_nr      = CW'(read_end_addr)  - CW'(read_start_addr)  + CW'(1);
  assign w_nw      = CW'(write_end_addr) - CW'(write_start_addr) + CW'(1);
  assign w_cfg_bad = (read_end_addr  < read_start_addr)  ||
                     (write_end_addr < write_start_addr) ||
                     (w_nr > (w_nw << 1));

  assign w_last_rd = (r_rptr == r_rd_end);

  // Sequencer state, pointers, operands and all registered strobes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_rd_end <= '0;
      r_half   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_buf_we <= 1'b0;
      r_wr_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else begin
      // Strobes are single-cycle unless a transition below re-arms them.
      r_rd_en  <= 1'b0;
      r_buf_we <= 1'b0;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_rptr   <= read_start_addr;
              r_wptr   <= write_start_addr;
              r_rd_end <= read_end_addr;
              r_half   <= 1'b0;
              r_rd_en  <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= S_READ;
            end
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid now, one cycle after the read strobe.
          r_op_a   <= rd_data_i[MEM_WORD_SIZE-1:DATA_W];
          r_op_b   <= rd_data_i[DATA_W-1:0];
          r_buf_we <= 1'b1;
          r_state  <= S_ADD;
        end
        S_ADD: begin
          if (!r_half && !w_last_rd) begin
            r_half  <= 1'b1;
            r_rptr  <= r_rptr + ADDR_W'(1);
            r_rd_en <= 1'b1;
            r_state <= S_READ;
          end else begin
            r_wr_en <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_last_rd) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rptr  <= r_rptr + ADDR_W'(1);
            r_wptr  <= r_wptr + ADDR_W'(1);
            r_half  <= 1'b0;
            r_rd_en <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write data follows the buffer; a lone final sum (half still 0) gets a zero upper half.
  always_comb begin
    w_wr_data = '0;
    if (r_wr_en) begin
      if (r_half) begin
        w_wr_data = buf_data_i;
      end else begin
        w_wr_data = {{(MEM_WORD_SIZE-DATA_W){1'b0}}, buf_data_i[DATA_W-1:0]};
      end
    end
  end

  assign rd_en_o   = r_rd_en;
  assign rd_addr_o = r_rptr;
  assign op_a_o    = r_op_a;
  assign op_b_o    = r_op_b;
  assign buf_we_o  = r_buf_we;
  assign buf_sel_o = r_half;
  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wptr;
  assign wr_data_o = w_wr_data;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: drives calc_sequencer against behavioural SRAM, adder and result buffer,
// and compares every packed write, job latency and status pulse with a pair-sum reference model.
module tb_calc_sequencer;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] rsa = '0, rea = '0, wsa = '0, wea = '0;
  logic          rd_en, buf_we, buf_sel, wr_en, busy, done, err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] op_a, op_b, sum_w;
  logic [MW-1:0] wr_data;
  logic [MW-1:0] rd_data_q = '0;
  logic [MW-1:0] buf_q = '0;

  calc_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .read_start_addr(rsa), .read_end_addr(rea),
    .write_start_addr(wsa), .write_end_addr(wea),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data_q),
    .op_a_o(op_a), .op_b_o(op_b), .sum_i(sum_w),
    .buf_we_o(buf_we), .buf_sel_o(buf_sel), .buf_data_i(buf_q),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk_i = ~clk_i;

  // Environment: SRAM with 1-cycle read, combinational adder, 64-bit result buffer.
  bit   [MW-1:0] mem     [512];
  bit   [MW-1:0] ref_mem [512];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [MW-1:0] pl_dat = '0;

  assign sum_w = op_a + op_b;

  always @(posedge clk_i) begin
    if (rd_en) rd_data_q <= mem[rd_addr];
    if (pl_we) mem[pl_addr] <= pl_dat;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (buf_we) begin
      if (buf_sel) buf_q[63:32] <= sum_w;
      else         buf_q[31:0]  <= sum_w;
    end
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor, sampled mid-cycle.
  int            n_rd = 0, n_wr = 0, n_done = 0, n_err = 0, n_busy = 0, n_ovl = 0;
  int            done_cyc = 0, err_cyc = 0;
  logic [AW-1:0] log_addr [1024];
  logic [MW-1:0] log_dat  [1024];

  always @(negedge clk_i) begin
    if (rd_en) n_rd <= n_rd + 1;
    if (wr_en && n_wr < 1024) begin
      log_addr[n_wr] <= wr_addr;
      log_dat[n_wr]  <= wr_data;
    end
    if (wr_en) n_wr <= n_wr + 1;
    if (rd_en && wr_en) n_ovl <= n_ovl + 1;
    if (busy) n_busy <= n_busy + 1;
    if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (err)  begin n_err  <= n_err + 1;  err_cyc  <= cyc; end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic preload(input int a, input logic [MW-1:0] d);
    pl_we   = 1'b1;
    pl_addr = AW'(a);
    pl_dat  = d;
    ref_mem[a] = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic fill(input int a0, input int a1);
    for (int a = a0; a <= a1; a++) preload(a, {$urandom, $urandom});
  endtask

  task automatic run(input int rs, input int re, input int ws, input int we,
                     input logic exp_busy, input string tag, output int s);
    rsa = AW'(rs); rea = AW'(re); wsa = AW'(ws); wea = AW'(we);
    start_i = 1'b1;
    s = cyc;
    tick();
    start_i = 1'b0;
    check({tag, "_busy_next_cycle"}, 64'(busy), 64'(exp_busy));
  endtask

  task automatic wait_end(input int d0, input int e0, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (n_done != d0 || n_err != e0) begin ok = 1'b1; break; end
    end
    check({tag, "_end_seen"}, 64'(ok), 64'd1);
  endtask

  // Reference: word j of the output = {sum(read word 2j+1) or 0, sum(read word 2j)}.
  logic [AW-1:0] exp_addr [256];
  logic [MW-1:0] exp_dat  [256];
  int            n_exp;

  task automatic model_job(input int rs, input int re, input int ws);
    int nr;
    logic [31:0] lo, hi;
    logic [63:0] w;
    nr = re - rs + 1;
    n_exp = 0;
    for (int j = 0; 2 * j < nr; j++) begin
      w  = ref_mem[rs + 2 * j];
      lo = w[63:32] + w[31:0];
      hi = 32'd0;
      if (2 * j + 1 < nr) begin
        w  = ref_mem[rs + 2 * j + 1];
        hi = w[63:32] + w[31:0];
      end
      exp_addr[j] = AW'(ws + j);
      exp_dat[j]  = {hi, lo};
      ref_mem[ws + j] = {hi, lo};
      n_exp++;
    end
  endtask

  task automatic check_job(input string tag, input int rs, input int re, input int ws,
                           input int s, input int d0, input int w0);
    int nr, nbad, got;
    nr = re - rs + 1;
    model_job(rs, re, ws);
    repeat (3) tick();
    got = n_wr - w0;
    check({tag, "_done_count"}, 64'(n_done), 64'(d0 + 1));
    check({tag, "_latency"}, 64'(done_cyc - s), 64'(3 * nr + (nr + 1) / 2 + 1));
    check({tag, "_write_count"}, 64'(got), 64'(n_exp));
    for (int j = 0; j < n_exp; j++) begin
      if (j < got) begin
        check($sformatf("%s_waddr%0d", tag, j), 64'(log_addr[w0 + j]), 64'(exp_addr[j]));
        check($sformatf("%s_wdata%0d", tag, j), log_dat[w0 + j], exp_dat[j]);
      end
    end
    nbad = 0;
    for (int a = 0; a < 512; a++) if (mem[a] != ref_mem[a]) nbad++;
    check({tag, "_mem_image"}, 64'(nbad), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  task automatic reject(input string tag, input int rs, input int re, input int ws, input int we);
    int s, d0, e0, r0, w0, b0;
    d0 = n_done; e0 = n_err; r0 = n_rd; w0 = n_wr; b0 = n_busy;
    run(rs, re, ws, we, 1'b0, tag, s);
    wait_end(d0, e0, tag);
    check({tag, "_err_cycle"}, 64'(err_cyc - s), 64'd1);
    repeat (3) tick();
    check({tag, "_err_count"}, 64'(n_err), 64'(e0 + 1));
    check({tag, "_no_reads"}, 64'(n_rd), 64'(r0));
    check({tag, "_no_writes"}, 64'(n_wr), 64'(w0));
    check({tag, "_never_busy"}, 64'(n_busy), 64'(b0));
    check({tag, "_no_done"}, 64'(n_done), 64'(d0));
  endtask

  initial begin
    int s, d0, w0, r0, rs, re, ws, we, nr, nwmin;

    // Reset state.
    repeat (3) tick();
    check("reset_ctl", {39'd0, rd_en, wr_en, buf_we, buf_sel, busy, done, err, rd_addr, wr_addr}, 64'd0);
    check("reset_wr_data", wr_data, 64'd0);
    check("reset_ops", {op_a, op_b}, 64'd0);
    rst_i = 1'b1;
    tick();

    // Two words, with a wrapping second sum.
    preload(0, {32'd5, 32'd7});
    preload(1, {32'hFFFF_FFFF, 32'd1});
    d0 = n_done; w0 = n_wr;
    run(0, 1, 16, 16, 1'b1, "two_word", s);
    wait_end(d0, n_err, "two_word");
    check_job("two_word", 0, 1, 16, s, d0, w0);
    check("two_word_literal", mem[16], 64'h0000_0000_0000_000C);

    // Odd read count leaves a zero upper half in the last write.
    for (int a = 4; a <= 6; a++) preload(a, {32'd1, 32'd2});
    d0 = n_done; w0 = n_wr;
    run(4, 6, 20, 21, 1'b1, "odd", s);
    wait_end(d0, n_err, "odd");
    check_job("odd", 4, 6, 20, s, d0, w0);
    check("odd_addr21_literal", mem[21], 64'h0000_0000_0000_0003);

    // Single word, read and write at the same address, sum wraps to zero.
    preload(9, {32'h8000_0000, 32'h8000_0000});
    d0 = n_done; w0 = n_wr;
    run(9, 9, 9, 9, 1'b1, "single", s);
    wait_end(d0, n_err, "single");
    check_job("single", 9, 9, 9, s, d0, w0);

    // Rejected configurations.
    reject("rej_rd_order", 10, 2, 0, 5);
    reject("rej_too_few", 0, 5, 0, 1);
    reject("rej_wr_order", 0, 1, 7, 6);

    // Boundary: NR exactly 2*NW is accepted.
    fill(40, 43);
    d0 = n_done; w0 = n_wr;
    run(40, 43, 500, 501, 1'b1, "exact_fit", s);
    wait_end(d0, n_err, "exact_fit");
    check_job("exact_fit", 40, 43, 500, s, d0, w0);

    // start_i while busy with different addresses is ignored.
    fill(100, 105);
    d0 = n_done; w0 = n_wr;
    run(100, 105, 300, 302, 1'b1, "busy_start", s);
    repeat (4) tick();
    rsa = AW'(0); rea = AW'(1); wsa = AW'(16); wea = AW'(16);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_end(d0, n_err, "busy_start");
    check_job("busy_start", 100, 105, 300, s, d0, w0);

    // Randomized jobs on disjoint ranges.
    for (int k = 0; k < 6; k++) begin
      nr    = $urandom_range(1, 12);
      rs    = $urandom_range(0, 200);
      re    = rs + nr - 1;
      nwmin = (nr + 1) / 2;
      ws    = $urandom_range(256, 400);
      we    = ws + $urandom_range(nwmin, nwmin + 3) - 1;
      fill(rs, re);
      d0 = n_done; w0 = n_wr;
      run(rs, re, ws, we, 1'b1, $sformatf("rnd%0d", k), s);
      wait_end(d0, n_err, $sformatf("rnd%0d", k));
      check_job($sformatf("rnd%0d", k), rs, re, ws, s, d0, w0);
    end

    // Reset during WAIT abandons the job.
    fill(30, 33);
    d0 = n_done; w0 = n_wr; r0 = n_rd;
    run(30, 33, 450, 451, 1'b1, "midrst", s);
    tick();
    rst_i = 1'b0;
    #1;
    check("midrst_ctl", {39'd0, rd_en, wr_en, buf_we, buf_sel, busy, done, err, rd_addr, wr_addr}, 64'd0);
    check("midrst_wr_data", wr_data, 64'd0);
    check("midrst_ops", {op_a, op_b}, 64'd0);
    repeat (2) tick();
    rst_i = 1'b1;
    repeat (20) tick();
    check("midrst_no_write", 64'(n_wr), 64'(w0));
    check("midrst_no_done", 64'(n_done), 64'(d0));
    check("midrst_one_read", 64'(n_rd - r0), 64'd1);
    check("midrst_idle", 64'(busy), 64'd0);
    check("midrst_mem_451", mem[451], ref_mem[451]);

    check("rd_wr_overlap", 64'(n_ovl), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequences the calculator datapath (dual SRAM read port, 32-bit adder, 64-bit result buffer, SRAM write port) for one batch job. After a start pulse it walks a read address range and adds the upper/lower 32-bit halves of each 64-bit read word. It packs pairs of sums into the result buffer and writes each packed word to a write address range. It sits between the top level's memory configuration inputs and the SRAM/adder/result-buffer instances, and drives every one of their control signals.

## Interface
- ADDR_W, 9, SRAM word address width
- DATA_W, 32, operand/sum width
- MEM_WORD_SIZE, 64, SRAM word width (two SRAMs side by side: upper = A, lower = B)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  job start pulse; sampled only in IDLE
- read_start_addr, read_end_addr  in  ADDR_W  inclusive read range; latched at start
- write_start_addr, write_end_addr  in  ADDR_W  inclusive write range; latched at start
- rd_en_o  out  1  read strobe, active-high (top inverts to csb1)
- rd_addr_o  out  ADDR_W  read address
- rd_data_i  in  MEM_WORD_SIZE  read data, valid the cycle after rd_en_o
- op_a_o, op_b_o  out  DATA_W  registered adder operands: rd_data_i[63:32], rd_data_i[31:0]
- sum_i  in  DATA_W  adder result (combinational from op_a_o/op_b_o)
- buf_we_o  out  1  result buffer capture strobe
- buf_sel_o  out  1  buffer half: 0 = lower [31:0], 1 = upper [63:32]
- buf_data_i  in  MEM_WORD_SIZE  result buffer contents
- wr_en_o  out  1  write strobe, active-high (top inverts to csb0/web0)
- wr_addr_o  out  ADDR_W  write address
- wr_data_o  out  MEM_WORD_SIZE  write data
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse on normal completion
- err_o  out  1  one-cycle pulse on rejected configuration

## Operation
- States: IDLE, READ, WAIT, ADD, WRITE, DONE.
- IDLE: start_i=1 latches all four addresses. Then it checks the configuration. Let NR = read_end-read_start+1 and NW = write_end-write_start+1. The job is rejected if read_end<read_start, write_end<write_start, or NR > 2*NW. On rejection, err_o pulses, the block stays in IDLE, and no strobes are issued. Otherwise it goes to READ with rptr=read_start, wptr=write_start, half=0.
- READ: rd_en_o=1, rd_addr_o=rptr; go to WAIT.
- WAIT: register op_a_o/op_b_o from rd_data_i; go to ADD.
- ADD: buf_we_o=1, buf_sel_o=half. The next state depends on half and whether rptr is the last address:
  - half=0 and rptr≠read_end: half←1, rptr++, go to READ.
  - half=1, or rptr=read_end: go to WRITE.
- WRITE: wr_en_o=1, wr_addr_o=wptr.
  - wr_data_o=buf_data_i, except for an odd final read (half=0 on the last word). In that case wr_data_o={32'h0, buf_data_i[31:0]}.
  - If rptr=read_end, go to DONE. Otherwise rptr++, wptr++, half←0, go to READ.
- DONE: done_o=1 for one cycle; go to IDLE.
- Sums wrap modulo 2^32; there is no carry or overflow output.
- Addresses never wrap. The range checks guarantee rptr≤read_end and wptr≤write_end.
- busy_o=1 in every state except IDLE.
- start_i is ignored outside IDLE.
- Address inputs that change during a job have no effect.
- The unused write range (wptr beyond the last written address) is never touched.
- Reset asserted mid-job: all state clears immediately. No further strobes are issued, and the job is abandoned, not resumed.

## Timing
- Reset values: state=IDLE. All strobes, busy_o, done_o, err_o, rd_addr_o, wr_addr_o, wr_data_o, op_a_o and op_b_o are 0.
- All outputs are registered or decoded from the state register. The only combinational dependency is wr_data_o on buf_data_i.
- Read latency is 1 cycle: data requested in READ is consumed in WAIT.
- The result buffer captures sum_i on the clk_i edge ending ADD. buf_data_i reflects it from the next cycle.
- Per read: 3 cycles (READ, WAIT, ADD). Per write: 1 cycle.
- A job of NR reads takes 3·NR + ceil(NR/2) cycles from the first READ cycle to the DONE cycle, plus 1 cycle for DONE.
- start_i in cycle t gives busy_o=1 from cycle t+1.
- err_o is asserted in cycle t+1; busy_o stays 0.
- rd_en_o and wr_en_o are never asserted in the same cycle.

## Test plan
- Reset: drive rst_i=0 mid-job (during WAIT) -> all outputs 0 the same cycle, state IDLE, no write occurs after release.
- Two-word read: read 0..1 holding {5,7} and {0xFFFFFFFF,1}, write 16..16 -> single write to addr 16 of 0x00000000_0000000C, done_o after 8 cycles.
- Odd count: read 4..6, write 20..21, each word {1,2} -> writes addr20={3,3}, addr21={0,3}. done_o pulses once; addr 22 is untouched.
- Rejection: read 10..2, or read 0..5 with write 0..1 (NR=6 > 4) -> err_o pulses 1 cycle; no rd_en_o or wr_en_o, busy_o stays 0.
- Start while busy: pulse start_i in the middle of a job with different addresses -> ignored; the original job completes with the original addresses.
- Single word: read 9..9, write 9..9, data {0x80000000,0x80000000} -> write addr 9 = 0x00000000_00000000 (wrapped sum), total 5 cycles to done_o.
